// File: rtl/count_seq_monitor.sv
// Monitors a modulo-2^WIDTH counter stream: acquires lock after LOCK_CNT correct increments,
// flags sequence breaks. Define COUNT_MON_STATS_EN to build the error/wrap statistics counters.
module count_seq_monitor #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic             cl,
  input  logic             r,
  input  logic             vld,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [WIDTH-1:0] exp_cnt,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count
);

  localparam int unsigned RUN_W = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_TGT = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCK} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev, w_prev_nxt, w_prev_inc;
  logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
  logic             w_match;
  logic             w_err;

  assign w_prev_inc = r_prev + WIDTH'(1);
  assign w_run_inc  = r_run + RUN_W'(1);
  assign w_match    = (cnt_in == w_prev_inc);

  always_ff @(posedge cl or negedge r) begin
    if (!r) begin
      r_state <= ST_IDLE;
      r_prev  <= '0;
      r_run   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_run   <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_run_nxt   = r_run;
    w_err       = 1'b0;
    if (vld) begin
      // Every valid sample becomes the new reference, matched or not.
      w_prev_nxt = cnt_in;
      case (r_state)
        ST_IDLE: begin
          w_run_nxt   = '0;
          w_state_nxt = ST_ACQ;
        end
        ST_ACQ: begin
          if (w_match) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == RUN_TGT) w_state_nxt = ST_LOCK;
          end else begin
            w_run_nxt = '0;
          end
        end
        ST_LOCK: begin
          if (!w_match) begin
            w_err       = 1'b1;
            w_run_nxt   = '0;
            w_state_nxt = ST_ACQ;
          end
        end
        default: begin
          w_run_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge cl or negedge r) begin
    if (!r) begin
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      exp_cnt    <= '0;
    end else begin
      locked    <= (w_state_nxt == ST_LOCK);
      err_pulse <= w_err;
      if (w_err)        err_sticky <= 1'b1;
      else if (clr_err) err_sticky <= 1'b0;
      exp_cnt <= (w_state_nxt == ST_IDLE) ? '0 : w_prev_nxt + WIDTH'(1);
    end
  end

`ifdef COUNT_MON_STATS_EN
  logic w_wrap;
  assign w_wrap = vld && (r_state == ST_LOCK) && w_match && (r_prev == '1);

  always_ff @(posedge cl or negedge r) begin
    if (!r) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      if (w_err && (err_count != '1))   err_count  <= err_count + 8'd1;
      if (w_wrap && (wrap_count != '1)) wrap_count <= wrap_count + 8'd1;
    end
  end
`else
  assign err_count  = '0;
  assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor (WIDTH=4, LOCK_CNT=2); expectations are hand-computed.
module tb_count_seq_monitor;

  logic       cl = 1'b0;
  logic       r = 1'b0;
  logic       vld = 1'b0;
  logic [3:0] cnt_in = '0;
  logic       clr_err = 1'b0;
  logic       locked, err_pulse, err_sticky;
  logic [3:0] exp_cnt;
  logic [7:0] err_count, wrap_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

`ifdef COUNT_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  count_seq_monitor #(.WIDTH(4), .LOCK_CNT(2)) u_dut (
    .cl(cl), .r(r), .vld(vld), .cnt_in(cnt_in), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .exp_cnt(exp_cnt), .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 cl = ~cl;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] v, input logic c);
    @(negedge cl);
    vld = 1'b1; cnt_in = v; clr_err = c;
    @(posedge cl); #1;
    vld = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle(input logic c);
    @(negedge cl);
    vld = 1'b0; clr_err = c;
    @(posedge cl); #1;
    clr_err = 1'b0;
  endtask

  function automatic logic [31:0] stat(input int unsigned n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    #12;
    check_eq("rst_locked",  32'(locked), 0);
    check_eq("rst_pulse",   32'(err_pulse), 0);
    check_eq("rst_sticky",  32'(err_sticky), 0);
    check_eq("rst_exp",     32'(exp_cnt), 0);
    check_eq("rst_errcnt",  32'(err_count), 0);
    check_eq("rst_wrapcnt", 32'(wrap_count), 0);
    @(negedge cl); r = 1'b1;

    // Acquisition: 3,4,5
    push(4'd3, 1'b0);
    check_eq("acq_first_exp",    32'(exp_cnt), 4);
    check_eq("acq_first_locked", 32'(locked), 0);
    check_eq("acq_first_pulse",  32'(err_pulse), 0);
    push(4'd4, 1'b0);
    check_eq("acq_4_locked", 32'(locked), 0);
    push(4'd5, 1'b0);
    check_eq("lock_locked", 32'(locked), 1);
    check_eq("lock_exp",    32'(exp_cnt), 6);
    check_eq("lock_sticky", 32'(err_sticky), 0);

    // Run through the wrap 15 -> 0
    for (int v = 6; v <= 17; v++) push(4'(v), 1'b0);
    check_eq("wrap_locked",  32'(locked), 1);
    check_eq("wrap_sticky",  32'(err_sticky), 0);
    check_eq("wrap_exp",     32'(exp_cnt), 2);
    check_eq("wrap_count",   32'(wrap_count), stat(1));
    check_eq("wrap_errcnt",  32'(err_count), 0);

    // Break at 5 -> 7
    for (int v = 2; v <= 5; v++) push(4'(v), 1'b0);
    push(4'd7, 1'b0);
    check_eq("brk_pulse",  32'(err_pulse), 1);
    check_eq("brk_sticky", 32'(err_sticky), 1);
    check_eq("brk_locked", 32'(locked), 0);
    check_eq("brk_exp",    32'(exp_cnt), 8);
    check_eq("brk_errcnt", 32'(err_count), stat(1));
    idle(1'b0);
    check_eq("brk_pulse_one_cycle", 32'(err_pulse), 0);
    check_eq("brk_sticky_held",     32'(err_sticky), 1);
    push(4'd8, 1'b0);
    check_eq("relock_8_locked", 32'(locked), 0);
    check_eq("relock_8_pulse",  32'(err_pulse), 0);
    push(4'd9, 1'b0);
    check_eq("relock_9_locked", 32'(locked), 1);

    idle(1'b1);
    check_eq("clr_alone_sticky", 32'(err_sticky), 0);

    // Long vld-low gap while locked, then repeat value
    for (int i = 0; i < 10; i++) idle(1'b0);
    check_eq("gap_locked", 32'(locked), 1);
    check_eq("gap_exp",    32'(exp_cnt), 10);
    push(4'd10, 1'b0);
    check_eq("gap_next_locked", 32'(locked), 1);
    check_eq("gap_next_pulse",  32'(err_pulse), 0);
    push(4'd10, 1'b0);
    check_eq("repeat_pulse",  32'(err_pulse), 1);
    check_eq("repeat_locked", 32'(locked), 0);
    check_eq("repeat_exp",    32'(exp_cnt), 11);
    check_eq("repeat_errcnt", 32'(err_count), stat(2));

    // Error with clr_err in the same cycle: set wins
    push(4'd11, 1'b0);
    push(4'd12, 1'b0);
    check_eq("pre_clr_locked", 32'(locked), 1);
    idle(1'b1);
    check_eq("pre_clr_sticky", 32'(err_sticky), 0);
    push(4'd5, 1'b1);
    check_eq("errclr_sticky",  32'(err_sticky), 1);
    check_eq("errclr_pulse",   32'(err_pulse), 1);
    check_eq("errclr_errcnt",  32'(err_count), stat(3));
    idle(1'b1);
    check_eq("clr_next_sticky", 32'(err_sticky), 0);
    check_eq("clr_next_pulse",  32'(err_pulse), 0);

    // Asynchronous reset mid-lock
    push(4'd6, 1'b0);
    push(4'd7, 1'b0);
    check_eq("prerst_locked", 32'(locked), 1);
    @(negedge cl); #2; r = 1'b0; #1;
    check_eq("arst_locked",  32'(locked), 0);
    check_eq("arst_exp",     32'(exp_cnt), 0);
    check_eq("arst_errcnt",  32'(err_count), 0);
    check_eq("arst_wrapcnt", 32'(wrap_count), 0);
    @(negedge cl); r = 1'b1;
    push(4'd9, 1'b0);
    check_eq("post_rst_locked", 32'(locked), 0);
    check_eq("post_rst_pulse",  32'(err_pulse), 0);
    check_eq("post_rst_exp",    32'(exp_cnt), 10);
    check_eq("post_rst_sticky", 32'(err_sticky), 0);
    push(4'd11, 1'b0);
    check_eq("acq_mis_pulse",  32'(err_pulse), 0);
    check_eq("acq_mis_sticky", 32'(err_sticky), 0);
    check_eq("acq_mis_exp",    32'(exp_cnt), 12);
    check_eq("acq_mis_locked", 32'(locked), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
